// File: rtl/mmio_pkg.sv
// Shared constants for the data-side MMIO block: register addresses,
// RAM region tag and TXSTAT bit layout.
package mmio_pkg;

  localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_TXSTAT = 32'hFFFF_0004;
  localparam logic [31:0] ADDR_CYCLES = 32'hFFFF_0008;
  localparam logic [3:0]  RAM_TAG     = 4'h0;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_MSB = 7;

  // Word-granular address compare; the byte offset never takes part in decode.
  function automatic logic word_match(input logic [29:0] addr_word, input logic [29:0] target_word);
    return addr_word == target_word;
  endfunction

endpackage

// File: rtl/data_port_mmio_if.sv
// Core data port plus the TX byte-sink handshake, as seen by the MMIO block.
interface data_port_mmio_if;
  logic [31:0] data_addr;
  logic [31:0] data_out;
  logic        data_wr;
  logic [31:0] data_in;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output data_addr, data_out, data_wr, tx_ready,
    input  data_in, tx_data, tx_valid
  );

  modport slave (
    input  data_addr, data_out, data_wr, tx_ready,
    output data_in, tx_data, tx_valid
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with explicit occupancy count; a push while full is
// accepted only when a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             empty_s;
  logic             full_s;
  logic             do_pop_s;
  logic             do_push_s;

  assign empty_s   = (count_r == '0);
  assign full_s    = (count_r == CNT_DEPTH);
  assign do_pop_s  = pop && !empty_s;
  assign do_push_s = push && (!full_s || do_pop_s);

  // Storage array; no reset so it maps onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = empty_s ? '0 : mem_r[rd_ptr_r];
  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;

endmodule

// File: rtl/data_port_mmio.sv
// Data-side memory system for the single-cycle core: word RAM, free-running
// cycle counter and a byte TX FIFO, with a combinational load path.
module data_port_mmio
  import mmio_pkg::*;
#(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 8
) (
  input logic             clk,
  input logic             rst,
  data_port_mmio_if.slave bus
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       ram_r [RAM_WORDS];
  logic [31:0]       cycles_r;
  logic              overflow_r;
  logic [RAM_AW-1:0] ram_idx_s;
  logic              sel_ram_s;
  logic              sel_txdata_s;
  logic              sel_txstat_s;
  logic              sel_cycles_s;
  logic              push_s;
  logic              pop_s;
  logic [7:0]        fifo_dout_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CW-1:0]     fifo_count_s;
  logic [3:0]        count_sat_s;
  logic [31:0]       stat_s;
  logic [31:0]       data_in_s;
  logic              unused_addr_s;

  assign unused_addr_s = ^bus.data_addr[1:0];

  assign ram_idx_s    = bus.data_addr[RAM_AW+1:2];
  assign sel_ram_s    = (bus.data_addr[31:28] == RAM_TAG);
  assign sel_txdata_s = word_match(bus.data_addr[31:2], ADDR_TXDATA[31:2]);
  assign sel_txstat_s = word_match(bus.data_addr[31:2], ADDR_TXSTAT[31:2]);
  assign sel_cycles_s = word_match(bus.data_addr[31:2], ADDR_CYCLES[31:2]);

  assign push_s = bus.data_wr && sel_txdata_s;
  assign pop_s  = !fifo_empty_s && bus.tx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (bus.data_out[7:0]),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Word RAM store port; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.data_wr && sel_ram_s) begin
      ram_r[ram_idx_s] <= bus.data_out;
    end
  end

  // Cycle counter; a store on the same edge wins over the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_r <= 32'd0;
    end else if (bus.data_wr && sel_cycles_s) begin
      cycles_r <= bus.data_out;
    end else begin
      cycles_r <= cycles_r + 32'd1;
    end
  end

  // Sticky overflow: a push that the full FIFO could not take, cleared by any TXSTAT store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (bus.data_wr && sel_txstat_s) begin
      overflow_r <= 1'b0;
    end else if (push_s && fifo_full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign count_sat_s = (32'(fifo_count_s) > 32'd15) ? 4'hF : 4'(fifo_count_s);

  // TXSTAT word assembly.
  always_comb begin
    stat_s                            = 32'd0;
    stat_s[STAT_FULL]                 = fifo_full_s;
    stat_s[STAT_EMPTY]                = fifo_empty_s;
    stat_s[STAT_OVF]                  = overflow_r;
    stat_s[STAT_CNT_MSB:STAT_CNT_LSB] = count_sat_s;
  end

  // Load data mux; TXDATA and unmapped addresses read as zero.
  always_comb begin
    data_in_s = 32'd0;
    if (sel_ram_s) begin
      data_in_s = ram_r[ram_idx_s];
    end else if (sel_txstat_s) begin
      data_in_s = stat_s;
    end else if (sel_cycles_s) begin
      data_in_s = cycles_r;
    end else begin
      data_in_s = 32'd0;
    end
  end

  assign bus.data_in  = data_in_s;
  assign bus.tx_data  = fifo_dout_s;
  assign bus.tx_valid = !fifo_empty_s;

endmodule
